// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: reads the word at the current PC from
// instruction memory using a req/ack handshake and latches it into the
// instruction register. On each successful fetch it pulses PC_LD so the PC
// advances. A bounded wait counter turns a silent memory into a sticky
// FETCH_ERR, and a later START retries the same address.
module ifetch_ctrl #(
  parameter int WAIT_MAX = 15
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [15:0] PC_ADDR,
  input  logic        START,
  output logic [15:0] MEM_ADDR,
  output logic        MEM_REQ,
  input  logic        MEM_ACK,
  input  logic [15:0] MEM_DATA,
  output logic [15:0] IR_OUT,
  output logic        IR_VALID,
  input  logic        IR_TAKE,
  output logic        PC_LD,
  output logic        BUSY,
  output logic        FETCH_ERR
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  // Counter value during the last REQ cycle that may still be acknowledged.
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FULL,
    ERR
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // Fetch FSM. Every output is registered, and PC_LD defaults low so that
  // it is high for only one cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      cnt       <= '0;
      MEM_ADDR  <= '0;
      MEM_REQ   <= 1'b0;
      IR_OUT    <= '0;
      IR_VALID  <= 1'b0;
      PC_LD     <= 1'b0;
      BUSY      <= 1'b0;
      FETCH_ERR <= 1'b0;
    end else begin
      PC_LD <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            MEM_ADDR <= PC_ADDR;
            MEM_REQ  <= 1'b1;
            BUSY     <= 1'b1;
            cnt      <= '0;
            state    <= REQ;
          end
        end

        REQ: begin
          // An ack in the final allowed cycle still counts as a success.
          if (MEM_ACK) begin
            IR_OUT   <= MEM_DATA;
            IR_VALID <= 1'b1;
            MEM_REQ  <= 1'b0;
            BUSY     <= 1'b0;
            PC_LD    <= 1'b1;
            state    <= FULL;
          end else if (cnt == CNT_LAST) begin
            cnt       <= cnt + CW'(1);
            MEM_REQ   <= 1'b0;
            BUSY      <= 1'b0;
            FETCH_ERR <= 1'b1;
            state     <= ERR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        FULL: begin
          // PC_ADDR already shows the advanced PC by the time the word is
          // consumed, so a back-to-back fetch can sample it directly.
          if (IR_TAKE) begin
            IR_VALID <= 1'b0;
            if (START) begin
              MEM_ADDR <= PC_ADDR;
              MEM_REQ  <= 1'b1;
              BUSY     <= 1'b1;
              cnt      <= '0;
              state    <= REQ;
            end else begin
              state <= IDLE;
            end
          end
        end

        ERR: begin
          // The PC was not advanced, so a retry fetches the same address.
          if (START) begin
            FETCH_ERR <= 1'b0;
            MEM_ADDR  <= PC_ADDR;
            MEM_REQ   <= 1'b1;
            BUSY      <= 1'b1;
            cnt       <= '0;
            state     <= REQ;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl. Two instances (WAIT_MAX=15 and WAIT_MAX=4) share
// the same stimulus and are each compared every cycle against a
// transaction-level model of the fetch rules.
module tb_ifetch_ctrl;

  logic        CLK;
  logic        RESET_N;
  logic [15:0] PC_ADDR;
  logic        START;
  logic        MEM_ACK;
  logic [15:0] MEM_DATA;
  logic        IR_TAKE;

  logic [15:0] a_addr, a_ir, b_addr, b_ir;
  logic        a_req, a_valid, a_pcld, a_busy, a_err;
  logic        b_req, b_valid, b_pcld, b_busy, b_err;

  ifetch_ctrl #(.WAIT_MAX(15)) dut_a (
    .CLK(CLK), .RESET_N(RESET_N), .PC_ADDR(PC_ADDR), .START(START),
    .MEM_ADDR(a_addr), .MEM_REQ(a_req), .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA),
    .IR_OUT(a_ir), .IR_VALID(a_valid), .IR_TAKE(IR_TAKE), .PC_LD(a_pcld),
    .BUSY(a_busy), .FETCH_ERR(a_err)
  );

  ifetch_ctrl #(.WAIT_MAX(4)) dut_b (
    .CLK(CLK), .RESET_N(RESET_N), .PC_ADDR(PC_ADDR), .START(START),
    .MEM_ADDR(b_addr), .MEM_REQ(b_req), .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA),
    .IR_OUT(b_ir), .IR_VALID(b_valid), .IR_TAKE(IR_TAKE), .PC_LD(b_pcld),
    .BUSY(b_busy), .FETCH_ERR(b_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Model state: is a fetch outstanding, how many unanswered cycles so far,
  // is an instruction waiting for decode, and is the error flag raised.
  typedef struct packed {
    bit          fetching;
    bit          holding;
    bit          err;
    bit          pc_ld;
    logic [7:0]  waited;
    logic [15:0] addr;
    logic [15:0] ir;
  } mstate_t;

  mstate_t ma, mb;
  int checks = 0;
  int failures = 0;
  bit track_pc = 0;
  logic [15:0] pc = 16'h0;

  function automatic mstate_t model_step(mstate_t s, int wmax, logic start,
                                         logic ack, logic [15:0] data,
                                         logic take, logic [15:0] pcv);
    mstate_t n = s;
    n.pc_ld = 1'b0;
    if (s.fetching) begin
      if (ack) begin
        n.ir = data;
        n.holding = 1'b1;
        n.fetching = 1'b0;
        n.pc_ld = 1'b1;
      end else begin
        n.waited = s.waited + 8'd1;
        if (int'(n.waited) == wmax) begin
          n.fetching = 1'b0;
          n.err = 1'b1;
        end
      end
    end else if (s.holding) begin
      if (take) begin
        n.holding = 1'b0;
        if (start) begin
          n.fetching = 1'b1;
          n.waited = 8'd0;
          n.addr = pcv;
        end
      end
    end else if (start) begin
      n.err = 1'b0;
      n.fetching = 1'b1;
      n.waited = 8'd0;
      n.addr = pcv;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    chk("a_addr", a_addr, ma.addr);
    chk("a_req", {15'd0, a_req}, {15'd0, ma.fetching});
    chk("a_ir", a_ir, ma.ir);
    chk("a_valid", {15'd0, a_valid}, {15'd0, ma.holding});
    chk("a_pcld", {15'd0, a_pcld}, {15'd0, ma.pc_ld});
    chk("a_busy", {15'd0, a_busy}, {15'd0, ma.fetching});
    chk("a_err", {15'd0, a_err}, {15'd0, ma.err});
    chk("b_addr", b_addr, mb.addr);
    chk("b_req", {15'd0, b_req}, {15'd0, mb.fetching});
    chk("b_ir", b_ir, mb.ir);
    chk("b_valid", {15'd0, b_valid}, {15'd0, mb.holding});
    chk("b_pcld", {15'd0, b_pcld}, {15'd0, mb.pc_ld});
    chk("b_busy", {15'd0, b_busy}, {15'd0, mb.fetching});
    chk("b_err", {15'd0, b_err}, {15'd0, mb.err});
  endtask

  // One clock edge: advance the models from the pre-edge inputs, then
  // compare just after the edge. The PC model increments as soon as PC_LD
  // shows up.
  task automatic tick();
    @(posedge CLK);
    if (!RESET_N) begin
      ma = '0;
      mb = '0;
    end else begin
      ma = model_step(ma, 15, START, MEM_ACK, MEM_DATA, IR_TAKE, PC_ADDR);
      mb = model_step(mb, 4, START, MEM_ACK, MEM_DATA, IR_TAKE, PC_ADDR);
    end
    #1;
    compare_all();
    if (track_pc) begin
      if (ma.pc_ld) pc = pc + 16'd1;
      PC_ADDR = pc;
    end
  endtask

  task automatic async_reset();
    RESET_N = 1'b0;
    #1;
    ma = '0;
    mb = '0;
    compare_all();
  endtask

  initial begin
    ma = '0;
    mb = '0;
    RESET_N = 1'b0;
    PC_ADDR = 16'h0;
    START = 1'b0;
    MEM_ACK = 1'b0;
    MEM_DATA = 16'h0;
    IR_TAKE = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
    tick();

    // Reset while a request is outstanding.
    PC_ADDR = 16'h1234; START = 1'b1;
    tick();
    chk("pre_rst_req", {15'd0, a_req}, 16'd1);
    async_reset();
    chk("rst_req", {15'd0, a_req}, 16'd0);
    chk("rst_addr", a_addr, 16'h0000);
    START = 1'b0;
    tick();
    RESET_N = 1'b1;
    PC_ADDR = 16'h0000; START = 1'b1;
    tick();
    chk("post_rst_req", {15'd0, a_req}, 16'd1);
    chk("post_rst_addr", a_addr, 16'h0000);
    START = 1'b0; MEM_ACK = 1'b1; MEM_DATA = 16'h0F0F;
    tick();
    IR_TAKE = 1'b1; MEM_ACK = 1'b0;
    tick();
    IR_TAKE = 1'b0;

    // Zero-wait fetch.
    PC_ADDR = 16'h0010; START = 1'b1; MEM_ACK = 1'b1; MEM_DATA = 16'hA5C3;
    tick();
    chk("zw_addr", a_addr, 16'h0010);
    chk("zw_pcld0", {15'd0, a_pcld}, 16'd0);
    tick();
    chk("zw_ir", a_ir, 16'hA5C3);
    chk("zw_valid", {15'd0, a_valid}, 16'd1);
    chk("zw_pcld1", {15'd0, a_pcld}, 16'd1);
    START = 1'b0;
    tick();
    chk("zw_pcld2", {15'd0, a_pcld}, 16'd0);
    IR_TAKE = 1'b1; MEM_ACK = 1'b0;
    tick();
    IR_TAKE = 1'b0;

    // Wait states: ack on the third REQ cycle.
    PC_ADDR = 16'h0040; START = 1'b1;
    tick();
    START = 1'b0; PC_ADDR = 16'h0099;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("ws_busy", {15'd0, a_busy}, 16'd1);
      chk("ws_addr", a_addr, 16'h0040);
    end
    MEM_ACK = 1'b1; MEM_DATA = 16'h7E11;
    tick();
    chk("ws_pcld", {15'd0, a_pcld}, 16'd1);
    chk("ws_err", {15'd0, b_err}, 16'd0);
    MEM_ACK = 1'b0; IR_TAKE = 1'b1;
    tick();
    IR_TAKE = 1'b0;

    // Timeout on the WAIT_MAX=4 instance, retry, then ack in the last cycle.
    PC_ADDR = 16'h0300; START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("to_err_early", {15'd0, b_err}, 16'd0);
    tick();
    chk("to_err", {15'd0, b_err}, 16'd1);
    chk("to_req", {15'd0, b_req}, 16'd0);
    START = 1'b1;
    tick();
    chk("retry_addr", b_addr, 16'h0300);
    chk("retry_err", {15'd0, b_err}, 16'd0);
    START = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    MEM_ACK = 1'b1; MEM_DATA = 16'hBEEF;
    tick();
    chk("last_ack_err", {15'd0, b_err}, 16'd0);
    chk("last_ack_ir", b_ir, 16'hBEEF);
    MEM_ACK = 1'b0; IR_TAKE = 1'b1;
    tick();
    IR_TAKE = 1'b0;

    // Back-to-back fetching with the PC model.
    track_pc = 1; pc = 16'h0020; PC_ADDR = 16'h0020;
    START = 1'b1; MEM_ACK = 1'b1; IR_TAKE = 1'b1; MEM_DATA = 16'h4444;
    tick(); chk("b2b_0", a_addr, 16'h0020);
    tick();
    tick(); chk("b2b_1", a_addr, 16'h0021);
    tick();
    tick(); chk("b2b_2", a_addr, 16'h0022);
    tick();
    START = 1'b0;
    tick();
    track_pc = 0; MEM_ACK = 1'b0; IR_TAKE = 1'b0;

    // Stall in FULL with spurious acks, then spurious acks in IDLE.
    PC_ADDR = 16'h0050; START = 1'b1; MEM_ACK = 1'b1; MEM_DATA = 16'h1357;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      MEM_ACK = 1'($urandom_range(0, 1));
      MEM_DATA = 16'($urandom);
      tick();
      chk("stall_ir", a_ir, 16'h1357);
      chk("stall_req", {15'd0, a_req}, 16'd0);
    end
    IR_TAKE = 1'b1; START = 1'b0;
    tick();
    IR_TAKE = 1'b0; MEM_ACK = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_ack_valid", {15'd0, a_valid}, 16'd0);
      chk("idle_ack_req", {15'd0, a_req}, 16'd0);
    end

    // Randomized traffic, with occasional asynchronous resets.
    track_pc = 1; pc = 16'($urandom); PC_ADDR = pc;
    for (int i = 0; i < 400; i++) begin
      START = ($urandom_range(0, 2) != 0);
      MEM_ACK = ($urandom_range(0, 3) == 0);
      MEM_DATA = 16'($urandom);
      IR_TAKE = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
        tick();
        RESET_N = 1'b1;
      end else begin
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
